// File: rtl/strip_frame_loader.sv
// Pixel-write front end for the LED-strip encoder: RGB writes land in a back buffer as GRB and
// are committed to `strip` in one rate-limited cycle. Define STRIP_FRAME_LOADER_CLEAR_EN to blank the buffer on commit.
module strip_frame_loader #(
  parameter int LENGTH    = 4,
  parameter int FRAME_GAP = 8356,
  parameter int IDX_W     = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [IDX_W-1:0]       wr_index,
  input  logic [23:0]            wr_color,
  input  logic                   wr_last,
  output logic [LENGTH*24-1:0]   strip,
  output logic                   strip_update,
  output logic [7:0]             commit_count,
  output logic                   idx_err
);

  localparam int GAP_W = $clog2(FRAME_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(FRAME_GAP);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 state_r;
  logic [LENGTH*24-1:0]   back_r;
  logic [GAP_W-1:0]       gap_r;
  logic [LENGTH-1:0]      wr_hit_s;
  logic                   in_range_s;
  logic                   accept_s;

  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  assign wr_ready = (state_r == FILL);
  assign accept_s = wr_valid && wr_ready;

  // One-hot decode of the write target; no hit means the index is past the strip.
  always_comb begin
    wr_hit_s = {LENGTH{1'b0}};
    for (int i = 0; i < LENGTH; i++) begin
      if (wr_index == IDX_W'(i)) begin
        wr_hit_s[i] = 1'b1;
      end else begin
        wr_hit_s[i] = 1'b0;
      end
    end
    in_range_s = |wr_hit_s;
  end

  // Frame FSM, back buffer, gap counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FILL;
      back_r       <= {(LENGTH*24){1'b0}};
      strip        <= {(LENGTH*24){1'b0}};
      gap_r        <= {GAP_W{1'b0}};
      commit_count <= 8'd0;
      idx_err      <= 1'b0;
      strip_update <= 1'b0;
    end else begin
      strip_update <= 1'b0;
      if (gap_r != GAP_MAX) begin
        gap_r <= gap_r + GAP_W'(1);
      end
      case (state_r)
        FILL: begin
          if (accept_s) begin
            for (int i = 0; i < LENGTH; i++) begin
              if (wr_hit_s[i]) begin
                back_r[i*24 +: 24] <= rgb_to_grb(wr_color);
              end
            end
            // Out-of-range data is dropped, but wr_last still closes the frame.
            if (!in_range_s) begin
              idx_err <= 1'b1;
            end
            if (wr_last) begin
              state_r <= HOLD;
            end
          end
        end
        HOLD: begin
          if (gap_r == GAP_MAX) begin
            strip        <= back_r;
            strip_update <= 1'b1;
            commit_count <= commit_count + 8'd1;
            gap_r        <= {GAP_W{1'b0}};
            state_r      <= FILL;
`ifdef STRIP_FRAME_LOADER_CLEAR_EN
            back_r       <= {(LENGTH*24){1'b0}};
`else
            back_r       <= back_r;
`endif
          end
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

endmodule
